datapath_seq: RTL
=================

# datapath_seq

Multi-cycle sequencer for the 4×32-bit register file and the 32-bit ALU. It accepts one register-to-register instruction through a valid/ready handshake. It then reads two source registers, drives the ALU, latches the result and writes it back to the destination register. It sits between the instruction source (testbench or fetch logic) and the register-file and ALU ports, and owns all register-file address and write-enable signals.

## Interface
Parameters:
- WIDTH, 32, datapath word width (register file and ALU).
- CNT_W, 8, width of the retired-instruction counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- instr_valid  in  1  instruction present on instr.
- instr  in  9  instruction: [8:6] op, [5:4] rs1, [3:2] rs2, [1:0] rd.
- instr_ready  out  1  sequencer can accept an instruction.
- rf_addr1  out  2  register-file read port 1 address (rs1).
- rf_addr2  out  2  register-file read port 2 address (rs2).
- rf_addr3  out  2  register-file write address (rd).
- rf_wr  out  1  register-file write enable.
- rf_wdata  out  WIDTH  register-file write data.
- rf_data1  in  WIDTH  read data, port 1 (asynchronous read).
- rf_data2  in  WIDTH  read data, port 2 (asynchronous read).
- alu_a  out  WIDTH  ALU operand A.
- alu_b  out  WIDTH  ALU operand B.
- alu_op  out  3  ALU operation select.
- alu_result  in  WIDTH  ALU combinational result.
- result  out  WIDTH  last written-back result.
- zero  out  1  1 when result == 0.
- done  out  1  one-cycle pulse when an instruction retires.
- retired  out  CNT_W  count of retired instructions.

## Operation
Op encoding:
- 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT (signed).
- 110 MOV: ALU passes A, so rd = rs1.
- 111 NOP: no writeback.
- The op field is forwarded unchanged on alu_op. The sequencer does not compute ALU functions itself.

States: IDLE, READ, EXEC, WB.
- IDLE: instr_ready=1. When instr_valid=1, latch instr into an internal instruction register and go to READ. Otherwise stay in IDLE.
- READ: rf_addr1/rf_addr2 carry the latched rs1/rs2. Capture rf_data1/rf_data2 into operand registers A/B. Go to EXEC.
- EXEC: alu_a=A, alu_b=B, alu_op=op.
  - Capture alu_result into the result register and update zero.
  - If op is not NOP, go to WB.
  - If op is NOP, skip the capture (result and zero hold), pulse done, increment retired, and go to IDLE.
- WB: rf_addr3=rd, rf_wr=1, rf_wdata=result register. Pulse done, increment retired, go to IDLE.

Output behaviour:
- rf_wr is 1 only in WB. It is never 1 in any other state or during reset.
- rf_addr1/2/3, alu_a/b and alu_op are driven from registered values. They stay stable between accepts. Bench must not rely on their values outside the stated states.
- rs1 == rs2 and rd == rs1/rs2 are legal. Operands are captured in READ, before the write in WB, so the old value is used.
- retired wraps modulo 2^CNT_W (255 → 0), with no saturation.

## Timing
- Accept in cycle T (IDLE, valid & ready).
- READ in T+1, EXEC in T+2, WB in T+3, with done=1 and the register-file write taking effect at the T+3 → T+4 edge.
- instr_ready=1 again in T+4. Peak throughput is one instruction per 4 cycles.
- NOP: done in T+2, instr_ready=1 in T+3.
- result and zero update at the T+2 → T+3 edge and hold until the next non-NOP EXEC.
- instr_valid while instr_ready=0 is ignored. The instruction is not queued, so the source must hold it until ready.
- Reset values:
  - State IDLE, instr_ready=1.
  - rf_wr=0, done=0, retired=0, result=0, zero=1.
  - All address, operand and alu_op outputs = 0.
- rst in any state takes priority. The next cycle is IDLE, the in-flight instruction is abandoned, and no write occurs even if rst arrives in WB.
- rst and instr_valid in the same cycle: the instruction is not accepted.
- The sequencer does not drive the register file's own reset.

## Test plan
- Register file preloaded R0=0x12345678, R1=0x9ABCDEF0, R2=0xFFFFFFFF, R3=0x00000001; bench ALU model.
  - ADD rs1=0 rs2=1 rd=2 → at T+3: rf_wr=1, rf_addr3=2, rf_wdata=0xACF13568, done=1.
  - After completion: R2=0xACF13568, retired=1, zero=0.
- SUB rs1=3 rs2=3 rd=0 → rf_wdata=0, zero=1, R0=0. Then SLT rs1=1 rs2=3 rd=1 → R1=0x00000001 (signed negative < 1).
- NOP with rd=2 → no rf_wr pulse at any cycle, done at T+2, instr_ready at T+3, result and zero unchanged.
- Back-to-back: instr_valid held high with 3 instructions → accepts exactly every 4 cycles. A pulse on instr_valid during READ/EXEC/WB is ignored (retired increments by accepted count only).
- Reset in WB of ADD rd=3 → rf_wr=0 in that cycle, R3 unchanged (0x00000001). Next cycle IDLE, retired=0, result=0, zero=1.
- 256 NOPs → retired wraps to 0, and done pulses exactly 256 times.

Source files
------------

// File: rtl/datapath_seq.sv
// datapath_seq: four-state sequencer that accepts one register-to-register
// instruction, reads two source registers, drives the external ALU, latches
// the result and writes it back to the destination register.
module datapath_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  input  logic [8:0]       instr,
  output logic             instr_ready,
  output logic [1:0]       rf_addr1,
  output logic [1:0]       rf_addr2,
  output logic [1:0]       rf_addr3,
  output logic             rf_wr,
  output logic [WIDTH-1:0] rf_wdata,
  input  logic [WIDTH-1:0] rf_data1,
  input  logic [WIDTH-1:0] rf_data2,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             done,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    WB   = 2'd3
  } state_t;

  localparam logic [2:0] OP_NOP = 3'b111;

  state_t             state;
  logic               ready_q;
  logic [8:0]         ir_p0;
  logic [WIDTH-1:0]   opa_p1;
  logic [WIDTH-1:0]   opb_p1;
  logic [WIDTH-1:0]   res_p2;
  logic               zero_q;
  logic               wr_q;
  logic               done_q;
  logic [CNT_W-1:0]   retired_q;

  logic               is_nop;

  assign is_nop = (ir_p0[8:6] == OP_NOP);

  // Sequencer: accept, operand read, ALU capture, writeback; reset wins in every state
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ready_q   <= 1'b1;
      ir_p0     <= '0;
      opa_p1    <= '0;
      opb_p1    <= '0;
      res_p2    <= '0;
      zero_q    <= 1'b1;
      wr_q      <= 1'b0;
      done_q    <= 1'b0;
      retired_q <= '0;
    end else begin
      case (state)
        // Stage boundary p0: instruction register loaded on accept
        IDLE: begin
          wr_q   <= 1'b0;
          done_q <= 1'b0;
          if (instr_valid) begin
            ir_p0   <= instr;
            ready_q <= 1'b0;
            state   <= READ;
          end
        end
        // Stage boundary p1: operands captured from the asynchronous read ports
        READ: begin
          opa_p1 <= rf_data1;
          opb_p1 <= rf_data2;
          done_q <= is_nop;
          state  <= EXEC;
        end
        // Stage boundary p2: ALU result captured, or a NOP retires here
        EXEC: begin
          if (is_nop) begin
            done_q    <= 1'b0;
            retired_q <= retired_q + CNT_W'(1);
            ready_q   <= 1'b1;
            state     <= IDLE;
          end else begin
            res_p2 <= alu_result;
            zero_q <= (alu_result == '0);
            wr_q   <= 1'b1;
            done_q <= 1'b1;
            state  <= WB;
          end
        end
        WB: begin
          wr_q      <= 1'b0;
          done_q    <= 1'b0;
          retired_q <= retired_q + CNT_W'(1);
          ready_q   <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          state   <= IDLE;
          ready_q <= 1'b1;
          wr_q    <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign instr_ready = ready_q;
  assign rf_addr1    = ir_p0[5:4];
  assign rf_addr2    = ir_p0[3:2];
  assign rf_addr3    = ir_p0[1:0];
  assign alu_op      = ir_p0[8:6];
  assign alu_a       = opa_p1;
  assign alu_b       = opb_p1;
  assign rf_wdata    = res_p2;
  // A reset arriving during writeback must suppress the write in that same cycle
  assign rf_wr       = wr_q & ~rst;
  assign result      = res_p2;
  assign zero        = zero_q;
  assign done        = done_q;
  assign retired     = retired_q;

endmodule
